// File: rtl/blake_round_ctrl.sv
// blake_round_ctrl
//   Sequencer for a BLAKE-512 compression datapath built around one G core.
//   It accepts one block per start/ready handshake and pulses init_round for
//   one cycle to load the state register. It then steps through
//   NUM_ROUNDS x G_PER_ROUND G operations, issuing round_idx, g_idx and
//   sigma_sel while asserting round_ing. After that it pulses finalize and
//   holds out_valid until out_ready.
//
//   Optional feature: define BLAKE_CTRL_ABORT_EN to add the abort/aborted
//   ports. With the macro undefined, only rst can stop a block once it has
//   started.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset; forces all outputs to 0
//   start       in   compress-one-block request, taken when start & ready
//   abort       in   (ABORT_EN) drop the block in INIT/ROUND/FINAL
//   aborted     out  (ABORT_EN) one-cycle flag in the first IDLE cycle after an abort
//   ready       out  idle, can accept start
//   init_round  out  load IV^constants into the state register
//   round_ing   out  state register takes v_state_next
//   round_idx   out  current round, 0 outside ROUND
//   sigma_sel   out  round_idx mod 10, 0 outside ROUND
//   g_idx       out  G step in round (0-3 column, 4-7 diagonal), 0 outside ROUND
//   finalize    out  v state is final; downstream computes h' this cycle
//   out_valid   out  hash result available
//   out_ready   in   downstream takes the result when out_valid & out_ready
//   busy        out  not IDLE
module blake_round_ctrl #(
    parameter int NUM_ROUNDS  = 16,
    parameter int G_PER_ROUND = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
`ifdef BLAKE_CTRL_ABORT_EN
    input  logic       abort,
    output logic       aborted,
`endif
    output logic       ready,
    output logic       init_round,
    output logic       round_ing,
    output logic [4:0] round_idx,
    output logic [3:0] sigma_sel,
    output logic [2:0] g_idx,
    output logic       finalize,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam logic [4:0] R_LAST = 5'(NUM_ROUNDS - 1);
    localparam logic [2:0] G_LAST = 3'(G_PER_ROUND - 1);

    state_e     state_q, state_d;
    logic [4:0] round_q, round_d;
    logic [2:0] g_q,     g_d;
    logic       abort_req;
    logic       abort_hit;

`ifdef BLAKE_CTRL_ABORT_EN
    logic aborted_q, aborted_d;
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Abort only bites while a block is in flight. A finished result in
    // DONE is left alone.
    assign abort_hit = abort_req &&
                       (state_q == S_INIT || state_q == S_ROUND || state_q == S_FINAL);

    // round_idx mod 10 for the full 0..31 range, without a divider
    function automatic logic [3:0] mod10(input logic [4:0] r);
        if (r >= 5'd30)      return 4'(r - 5'd30);
        else if (r >= 5'd20) return 4'(r - 5'd20);
        else if (r >= 5'd10) return 4'(r - 5'd10);
        else                 return 4'(r);
    endfunction

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        g_d     = g_q;
`ifdef BLAKE_CTRL_ABORT_EN
        aborted_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_INIT;
            end
            S_INIT: begin
                round_d = '0;
                g_d     = '0;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                if (g_q == G_LAST) begin
                    g_d = '0;
                    if (round_q == R_LAST) begin
                        // Clear the counters on exit so the index outputs idle at 0.
                        round_d = '0;
                        state_d = S_FINAL;
                    end else begin
                        round_d = round_q + 5'd1;
                    end
                end else begin
                    g_d = g_q + 3'd1;
                end
            end
            S_FINAL: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                round_d = '0;
                g_d     = '0;
            end
        endcase

        // Abort overrides every normal transition above.
        if (abort_hit) begin
            state_d = S_IDLE;
            round_d = '0;
            g_d     = '0;
`ifdef BLAKE_CTRL_ABORT_EN
            aborted_d = 1'b1;
`endif
        end
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            round_q <= '0;
            g_q     <= '0;
`ifdef BLAKE_CTRL_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            g_q     <= g_d;
`ifdef BLAKE_CTRL_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    // ---------------------------------------------------------------- outputs
    // Outputs are decoded from registered state only. rst additionally
    // blanks them, so nothing is visible in the cycle rst is raised, before
    // the reset edge.
    always_comb begin
        ready      = 1'b0;
        init_round = 1'b0;
        round_ing  = 1'b0;
        round_idx  = '0;
        sigma_sel  = '0;
        g_idx      = '0;
        finalize   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
`ifdef BLAKE_CTRL_ABORT_EN
        aborted    = 1'b0;
`endif
        if (!rst) begin
            busy = (state_q != S_IDLE);
            case (state_q)
                S_IDLE:  ready      = 1'b1;
                S_INIT:  init_round = 1'b1;
                S_ROUND: begin
                    round_ing = 1'b1;
                    round_idx = round_q;
                    sigma_sel = mod10(round_q);
                    g_idx     = g_q;
                end
                S_FINAL: finalize  = 1'b1;
                S_DONE:  out_valid = 1'b1;
                default: ;
            endcase
`ifdef BLAKE_CTRL_ABORT_EN
            aborted = aborted_q;
`endif
        end
    end

endmodule

// File: tb/tb_blake_round_ctrl.sv
module tb_blake_round_ctrl;

    localparam int NR = 16;
    localparam int GP = 8;
    localparam int NG = NR * GP;

    logic clk = 1'b0;
    logic rst, start, out_ready;
    logic ready, init_round, round_ing, finalize, out_valid, busy;
    logic [4:0] round_idx;
    logic [3:0] sigma_sel;
    logic [2:0] g_idx;
    logic abort;
`ifdef BLAKE_CTRL_ABORT_EN
    logic aborted;
`endif

    // small instance: NUM_ROUNDS=1, G_PER_ROUND=1
    logic start2, out_ready2;
    logic ready2, init_round2, round_ing2, finalize2, out_valid2, busy2;
    logic [4:0] round_idx2;
    logic [3:0] sigma_sel2;
    logic [2:0] g_idx2;
`ifdef BLAKE_CTRL_ABORT_EN
    logic aborted2;
`endif

    always #5 clk = ~clk;

    blake_round_ctrl #(.NUM_ROUNDS(NR), .G_PER_ROUND(GP)) dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef BLAKE_CTRL_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .ready(ready), .init_round(init_round), .round_ing(round_ing),
        .round_idx(round_idx), .sigma_sel(sigma_sel), .g_idx(g_idx),
        .finalize(finalize), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
    );

    blake_round_ctrl #(.NUM_ROUNDS(1), .G_PER_ROUND(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2),
`ifdef BLAKE_CTRL_ABORT_EN
        .abort(1'b0), .aborted(aborted2),
`endif
        .ready(ready2), .init_round(init_round2), .round_ing(round_ing2),
        .round_idx(round_idx2), .sigma_sel(sigma_sel2), .g_idx(g_idx2),
        .finalize(finalize2), .out_valid(out_valid2), .out_ready(out_ready2),
        .busy(busy2)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, obs, exp);
        end
    endtask

    // Reference model: a block is described only by how many cycles have
    // passed since its accept edge (m_t). The phase follows from that count:
    // 1 = init, 2..NG+1 = rounds, NG+2 = final, >= NG+3 = result held.
    bit m_act = 0;
    int m_t   = 0;
    bit m_ab  = 0;

    task automatic check_all();
        bit e_rdy, e_init, e_rnd, e_fin, e_ov, e_busy, e_ab;
        int e_r, e_g;
        e_rdy = 0; e_init = 0; e_rnd = 0; e_fin = 0; e_ov = 0; e_busy = 0;
        e_ab = 0; e_r = 0; e_g = 0;
        if (!rst) begin
            e_ab = m_ab;
            if (!m_act) e_rdy = 1;
            else begin
                e_busy = 1;
                if (m_t == 1) e_init = 1;
                else if (m_t <= NG + 1) begin
                    e_rnd = 1;
                    e_r   = (m_t - 2) / GP;
                    e_g   = (m_t - 2) % GP;
                end
                else if (m_t == NG + 2) e_fin = 1;
                else e_ov = 1;
            end
        end
        chk("ready",      32'(ready),      32'(e_rdy));
        chk("busy",       32'(busy),       32'(e_busy));
        chk("init_round", 32'(init_round), 32'(e_init));
        chk("round_ing",  32'(round_ing),  32'(e_rnd));
        chk("round_idx",  32'(round_idx),  32'(e_r));
        chk("g_idx",      32'(g_idx),      32'(e_g));
        chk("sigma_sel",  32'(sigma_sel),  32'(e_r % 10));
        chk("finalize",   32'(finalize),   32'(e_fin));
        chk("out_valid",  32'(out_valid),  32'(e_ov));
`ifdef BLAKE_CTRL_ABORT_EN
        chk("aborted",    32'(aborted),    32'(e_ab));
`else
        e_ab = 0;
`endif
    endtask

    task automatic model_edge();
        bit ab_now;
        ab_now = 0;
`ifdef BLAKE_CTRL_ABORT_EN
        ab_now = abort;
`endif
        if (rst) begin
            m_act = 0; m_ab = 0;
        end else if (m_act && ab_now && m_t <= NG + 2) begin
            m_act = 0; m_ab = 1;
        end else begin
            m_ab = 0;
            if (!m_act) begin
                if (start) begin m_act = 1; m_t = 1; end
            end else if (m_t >= NG + 3) begin
                if (out_ready) m_act = 0;
            end else begin
                m_t++;
            end
        end
    endtask

    // check in mid-cycle, update the model on the edge, then hand back
    task automatic tick();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    initial begin
        rst = 1; start = 1; out_ready = 0; abort = 0;
        start2 = 0; out_ready2 = 0;

        // reset held with start high: everything 0
        tick(); tick();
        rst = 0; start = 0;
        tick();
        chk("idle_ready", 32'(ready), 32'd1);
        chk("idle_busy",  32'(busy),  32'd0);

        // full block; DONE held 5 cycles with start pressed, then released
        start = 1; tick(); start = 0;       // accept edge
        repeat (NG + 2) tick();             // cycles 1..130
        chk("ov_at_131", 32'(out_valid), 32'd1);
        start = 1;
        repeat (5) tick();                  // DONE, out_ready low
        start = 0; out_ready = 1;
        tick();                             // 6th out_valid cycle, consumed
        out_ready = 0;
        chk("ready_after_done", 32'(ready), 32'd1);
        tick();

        // start re-pressed at 50, reset at 60
        start = 1; tick(); start = 0;
        repeat (49) tick();
        start = 1;
        repeat (10) tick();                 // cycles 50..59
        rst = 1; tick();                    // cycle 60
        rst = 0; start = 0;
        tick();                             // cycle 61: idle
        chk("idle_after_rst", 32'(ready), 32'd1);

`ifdef BLAKE_CTRL_ABORT_EN
        // abort at 70, restart at 71, full run
        start = 1; tick(); start = 0;
        repeat (69) tick();
        abort = 1; tick(); abort = 0;       // cycle 70
        chk("aborted_71", 32'(aborted), 32'd1);
        start = 1; tick(); start = 0;       // cycle 71: accepted
        out_ready = 1;
        repeat (NG + 3) tick();
        out_ready = 0;
`endif

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            start     = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 299) == 0);
            abort     = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 0; start = 0; abort = 0; out_ready = 1;
        repeat (NG + 5) tick();

        // minimal configuration: INIT c1, ROUND c2, FINAL c3, out_valid c4
        out_ready = 0; out_ready2 = 1;
        start2 = 1; tick(); start2 = 0;
        chk("s_init",   32'(init_round2), 32'd1);
        tick();
        chk("s_round",  32'(round_ing2),  32'd1);
        chk("s_ridx",   32'(round_idx2),  32'd0);
        chk("s_gidx",   32'(g_idx2),      32'd0);
        tick();
        chk("s_final",  32'(finalize2),   32'd1);
        chk("s_ov_lo",  32'(out_valid2),  32'd0);
        tick();
        chk("s_ov",     32'(out_valid2),  32'd1);
        tick();
        chk("s_ready",  32'(ready2),      32'd1);
        chk("s_ov_end", 32'(out_valid2),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
